// File: rtl/hex_display_ctrl_if.sv
// Application-side bundle for the HEX bank driver.
// master drives digit data and controls; slave returns the segment bus.
interface hex_display_ctrl_if #(
   parameter int DIGITS   = 6,
   parameter int PWM_BITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     blank_in;
   logic [DIGITS-1:0]     blink_in;
   logic                  lz_en;
   logic [PWM_BITS-1:0]   brightness;
   logic                  pending;
   logic [8*DIGITS-1:0]   seg;

   modport master (
      output load, value, dp_in, blank_in, blink_in,
      output lz_en, brightness,
      input  pending, seg
   );

   modport slave (
      input  load, value, dp_in, blank_in, blink_in,
      input  lz_en, brightness,
      output pending, seg
   );
endinterface

// File: rtl/hex_display_ctrl.sv
// Static N-digit seven-segment driver with blink, blank, dp,
// leading-zero suppression and PWM dimming; loads commit on frame edges.
module hex_display_ctrl #(
   parameter int DIGITS     = 6,
   parameter int CLK_HZ     = 50000000,
   parameter int BLINK_HZ   = 2,
   parameter int PWM_BITS   = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   hex_display_ctrl_if.slave bus
);

   localparam int PRE_MAX = CLK_HZ / (2 * BLINK_HZ) - 1;
   localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
   localparam logic [7:0] OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [4*DIGITS-1:0] sh_val, act_val;
   logic [DIGITS-1:0]   sh_dp, sh_blank, sh_blink;
   logic [DIGITS-1:0]   act_dp, act_blank, act_blink;
   logic                pend;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PRE_W-1:0]    pre;
   logic                phase;
   logic [8*DIGITS-1:0] seg_q, seg_next;
   logic                boundary;

   assign boundary    = &pwm_cnt;
   assign bus.pending = pend;
   assign bus.seg     = seg_q;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   endfunction

   always_comb begin
      logic [DIGITS-1:0] supp;
      logic              run;
      logic              lit;
      logic [7:0]        p;
      seg_next = '0;
      supp     = '0;
      run      = bus.lz_en;
      p        = 8'h00;
      lit      = (&bus.brightness) || (pwm_cnt < bus.brightness);
      // walk down from the top digit; digit 0 always shows
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (run && act_val[4*k +: 4] == 4'd0)
            supp[k] = 1'b1;
         else
            run = 1'b0;
      end
      for (int k = 0; k < DIGITS; k++) begin
         p = {act_dp[k], supp[k] ? 7'd0 : glyph(act_val[4*k +: 4])};
         if (act_blank[k] || !lit || (act_blink[k] && phase))
            p = 8'h00;
         seg_next[8*k +: 8] = ACTIVE_LOW ? ~p : p;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_val    <= '0;
         sh_dp     <= '0;
         sh_blank  <= '0;
         sh_blink  <= '0;
         act_val   <= '0;
         act_dp    <= '0;
         act_blank <= '0;
         act_blink <= '0;
         pend      <= 1'b0;
         pwm_cnt   <= '0;
         pre       <= '0;
         phase     <= 1'b0;
         seg_q     <= {DIGITS{OFF}};
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         seg_q   <= seg_next;
         if (pre == PRE_W'(PRE_MAX)) begin
            pre   <= '0;
            phase <= ~phase;
         end else begin
            pre <= pre + 1'b1;
         end
         // a load on the boundary wins over any older pending shadow
         if (boundary) begin
            pend <= 1'b0;
            if (bus.load) begin
               act_val   <= bus.value;
               act_dp    <= bus.dp_in;
               act_blank <= bus.blank_in;
               act_blink <= bus.blink_in;
            end else if (pend) begin
               act_val   <= sh_val;
               act_dp    <= sh_dp;
               act_blank <= sh_blank;
               act_blink <= sh_blink;
            end
         end else if (bus.load) begin
            sh_val   <= bus.value;
            sh_dp    <= bus.dp_in;
            sh_blank <= bus.blank_in;
            sh_blink <= bus.blink_in;
            pend     <= 1'b1;
         end
      end
   end

endmodule
